// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
//   Turns a one-cycle exception/interrupt/ERET decision into an ordered commit:
//   hold the pipeline, drain outstanding bus traffic, pulse the CP0 write,
//   flush the pipeline for FLUSH_CYCLES, then hand the redirect PC to fetch.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   exc_*_i                event decision and its attributes (sampled in IDLE)
//   bus_busy_i             bus has outstanding transactions
//   fetch_ready_i          fetch accepts the redirect
//   stall_o, flush_o       pipeline control
//   cp0_*_o                CP0 strobes and latched exception fields
//   redirect_valid_o/pc_o  redirect handshake towards fetch
//   drain_timeout_o        sticky: a drain ended by timeout
module exc_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DRAIN_MAX    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_flag_i,
    input  logic        exc_eret_i,
    input  logic [4:0]  exc_code_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_baddr_i,
    input  logic [31:0] exc_flush_pc_i,
    input  logic        bus_busy_i,
    input  logic        fetch_ready_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        cp0_we_o,
    output logic        cp0_eret_o,
    output logic [4:0]  cp0_code_o,
    output logic        cp0_bd_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_badv_we_o,
    output logic [31:0] cp0_badv_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        drain_timeout_o
);

    localparam logic [7:0] DrainLast = 8'(DRAIN_MAX - 1);
    localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StCommit,
        StFlush,
        StRedirect
    } state_e;

    state_e      state_q;
    logic [7:0]  drain_cnt_q;
    logic [3:0]  flush_cnt_q;

    // Event fields captured in the decision cycle
    logic        eret_q;
    logic [4:0]  code_q;
    logic        bd_q;
    logic [31:0] pc_q;
    logic [31:0] baddr_q;
    logic [31:0] flush_pc_q;

    // Registered outputs
    logic        flush_q;
    logic        cp0_we_q;
    logic        cp0_eret_q;
    logic        cp0_badv_we_q;
    logic        redirect_valid_q;
    logic        drain_timeout_q;

    logic        drain_done;
    logic        addr_err;

    // Leave DRAIN when the bus goes quiet or the budget runs out
    assign drain_done = !bus_busy_i || (drain_cnt_q == DrainLast);
    assign addr_err   = (code_q == 5'd4) || (code_q == 5'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            drain_cnt_q      <= 8'd0;
            flush_cnt_q      <= 4'd0;
            eret_q           <= 1'b0;
            code_q           <= 5'd0;
            bd_q             <= 1'b0;
            pc_q             <= 32'd0;
            baddr_q          <= 32'd0;
            flush_pc_q       <= 32'd0;
            flush_q          <= 1'b0;
            cp0_we_q         <= 1'b0;
            cp0_eret_q       <= 1'b0;
            cp0_badv_we_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            drain_timeout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (exc_flag_i) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= 8'd0;
                        eret_q      <= exc_eret_i;
                        code_q      <= exc_code_i;
                        bd_q        <= exc_bd_i;
                        pc_q        <= exc_pc_i;
                        baddr_q     <= exc_baddr_i;
                        flush_pc_q  <= exc_flush_pc_i;
                    end
                end
                StDrain: begin
                    drain_cnt_q <= drain_cnt_q + 8'd1;
                    if (drain_done) begin
                        state_q       <= StCommit;
                        cp0_we_q      <= !eret_q;
                        cp0_eret_q    <= eret_q;
                        cp0_badv_we_q <= !eret_q && addr_err;
                        // Still busy here means the budget expired
                        if (bus_busy_i) begin
                            drain_timeout_q <= 1'b1;
                        end
                    end
                end
                StCommit: begin
                    state_q       <= StFlush;
                    flush_cnt_q   <= 4'd0;
                    cp0_we_q      <= 1'b0;
                    cp0_eret_q    <= 1'b0;
                    cp0_badv_we_q <= 1'b0;
                    flush_q       <= 1'b1;
                end
                StFlush: begin
                    flush_cnt_q <= flush_cnt_q + 4'd1;
                    if (flush_cnt_q == FlushLast) begin
                        state_q          <= StRedirect;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end
                end
                StRedirect: begin
                    if (fetch_ready_i) begin
                        state_q          <= StIdle;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Combinational so the pipeline freezes in the decision cycle itself
    assign stall_o = exc_flag_i || (state_q != StIdle);

    assign flush_o          = flush_q;
    assign cp0_we_o         = cp0_we_q;
    assign cp0_eret_o       = cp0_eret_q;
    assign cp0_badv_we_o    = cp0_badv_we_q;
    assign redirect_valid_o = redirect_valid_q;
    assign drain_timeout_o  = drain_timeout_q;

    assign cp0_code_o    = code_q;
    assign cp0_bd_o      = bd_q;
    assign cp0_badv_o    = baddr_q;
    assign cp0_epc_o     = bd_q ? (pc_q - 32'd4) : pc_q;
    assign redirect_pc_o = flush_pc_q;

endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Sequencer that turns a one-cycle exception/interrupt/ERET decision from the exception stage into an ordered commit. It holds the pipeline, drains outstanding bus traffic, writes CP0 in a single pulse, flushes the pipeline for a fixed number of cycles, then hands the redirect PC to fetch with a valid/ready handshake. It sits between the exception stage, CP0, the pipeline control (stall/flush) and the fetch unit.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high (legal range 1..15)
- DRAIN_MAX, 64, maximum DRAIN cycles before forced progress (legal range 1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- exc_flag_i  in  1  exception/interrupt/ERET decided this cycle
- exc_eret_i  in  1  the decided event is ERET
- exc_code_i  in  5  CP0 Cause.ExcCode of the event
- exc_bd_i  in  1  faulting instruction is in a branch delay slot
- exc_pc_i  in  32  PC of the faulting instruction
- exc_baddr_i  in  32  bad virtual address
- exc_flush_pc_i  in  32  target PC (handler or ERET return)
- bus_busy_i  in  1  instruction or data bus has outstanding transactions
- fetch_ready_i  in  1  fetch accepts redirect
- stall_o  out  1  hold all pipeline stages
- flush_o  out  1  kill all in-flight instructions
- cp0_we_o  out  1  one-cycle CP0 exception write strobe
- cp0_eret_o  out  1  one-cycle EXL-clear strobe (ERET)
- cp0_code_o  out  5  latched ExcCode
- cp0_bd_o  out  1  latched BD bit
- cp0_epc_o  out  32  EPC value
- cp0_badv_we_o  out  1  one-cycle BadVAddr write strobe
- cp0_badv_o  out  32  latched bad address
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target
- drain_timeout_o  out  1  sticky: DRAIN ended by timeout

## Operation
- States: IDLE, DRAIN, COMMIT, FLUSH, REDIRECT. Reset -> IDLE.
- IDLE: when exc_flag_i=1, latch eret, code, bd, pc, baddr and flush_pc, clear the drain counter, and go to DRAIN. Otherwise stay.
- DRAIN: increment an 8-bit counter each cycle.
  - bus_busy_i=0 -> COMMIT.
  - Counter reaches DRAIN_MAX-1 with bus still busy -> COMMIT and set drain_timeout_o. The bit clears only on rst.
- COMMIT: one cycle, then FLUSH with the flush counter cleared.
  - Non-ERET: cp0_we_o=1.
  - Non-ERET with code 4 (AdEL) or 5 (AdES): cp0_badv_we_o=1.
  - ERET: cp0_eret_o=1 only; cp0_we_o=0 and cp0_badv_we_o=0.
- FLUSH: flush_o=1. The 4-bit counter increments; on the FLUSH_CYCLES-1 value go to REDIRECT.
- REDIRECT: redirect_valid_o=1 and redirect_pc_o=latched flush_pc.
  - redirect_valid_o and redirect_pc_o hold stable until fetch_ready_i=1.
  - The handshake cycle (valid & ready) -> IDLE.
- stall_o = exc_flag_i | (state != IDLE). This is combinational so the pipeline freezes in the decision cycle.
- exc_flag_i outside IDLE is ignored. The pipeline is stalled, so a new event re-presents after return to IDLE.
- cp0_epc_o = bd ? pc - 4 : pc. Arithmetic is 32-bit modulo 2^32: pc=0 with bd=1 gives 0xFFFF_FFFC.
- cp0_code_o, cp0_bd_o, cp0_badv_o and cp0_epc_o are driven from the latch and are valid whenever a strobe is high.

## Timing
- Reset values: stall_o=0 (with exc_flag_i=0), flush_o=0, cp0_we_o=0, cp0_eret_o=0, cp0_badv_we_o=0, redirect_valid_o=0, drain_timeout_o=0. All latched fields and cp0_epc_o are 0, and redirect_pc_o=0.
- Assertion of rst in any state returns to IDLE immediately. Strobes and redirect drop asynchronously, and the pending event is discarded.
- With the flag at T0 and bus idle at T1: DRAIN at T1, COMMIT strobes at T2, flush_o over T3..T2+FLUSH_CYCLES, redirect_valid_o from T3+FLUSH_CYCLES.
- Minimum flag-to-redirect latency is 3+FLUSH_CYCLES cycles. With fetch_ready_i=1, IDLE is reached one cycle after the handshake.
- Each strobe is exactly one cycle per event. flush_o is exactly FLUSH_CYCLES cycles, with no gap to redirect.
- A forced timeout commit occurs after DRAIN_MAX cycles in DRAIN.

## Test plan
- Idle-bus exception: pc=0x8000_1000, bd=0, code=0x0C, flush_pc=0xBFC0_0380, FLUSH_CYCLES=2. Required: cp0_we_o at T2 with epc=0x8000_1000; flush_o at T3–T4; redirect at T5 with pc 0xBFC0_0380; back to IDLE at T6.
- Delay-slot AdEL: pc=0x8000_2004, bd=1, code=4, baddr=0x0000_0003. Required: epc=0x8000_2000, cp0_badv_we_o=1 with 0x0000_0003, cp0_bd_o=1.
- ERET with flush_pc=0x8000_3000. Required: cp0_eret_o one cycle; no cp0_we_o and no cp0_badv_we_o; redirect pc 0x8000_3000.
- Drain behaviour:
  - bus_busy_i high for 5 cycles: COMMIT one cycle after busy drops; drain_timeout_o stays 0.
  - Busy held forever, DRAIN_MAX=8: COMMIT after 8 DRAIN cycles; drain_timeout_o=1 and stays 1.
- Backpressure and ignored flag: fetch_ready_i=0 for 4 cycles in REDIRECT. Required: valid and pc stable, stall_o=1. A second exc_flag_i pulse during FLUSH produces no second commit.
- Reset mid-FLUSH: all outputs go to 0 immediately; after release, a new flag restarts cleanly from DRAIN.
